// File: rtl/result_collector_pkg.sv
// result_collector_pkg
//   Shared definitions for the result collector and its neighbours.
//   - Collector state encoding (also decoded by the display stage).
//   - Result-memory geometry constants.
//   - Segment base addresses inside the result memory, grouped by the
//     compute run that produced the entries.
package result_collector_pkg;

    localparam int RC_DEPTH = 12;   // result entries, addresses 0..RC_DEPTH-1
    localparam int RC_IN_W  = 16;   // incoming unsigned accumulator width
    localparam int RC_AW    = 4;    // address width, 2**RC_AW >= RC_DEPTH

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DISPLAY = 2'd2
    } rc_state_t;

    // Result segments in write order: single PE, 2x2 array, 3x3 array.
    localparam logic [RC_AW-1:0] SEG_PE_BASE  = 4'd0;
    localparam logic [RC_AW-1:0] SEG_SA2_BASE = 4'd4;
    localparam logic [RC_AW-1:0] SEG_SA3_BASE = 4'd8;
    localparam int               SEG_LEN      = 4;

endpackage

// File: rtl/result_mem.sv
// result_mem
//   DEPTH x 8 register file holding saturated results.
//   Synchronous write, asynchronous (zero-latency) read, asynchronous
//   active-low clear of every entry. Reads outside 0..DEPTH-1 return 0.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low clear
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  entry at rd_addr (0 when out of range)
module result_mem
    import result_collector_pkg::*;
#(
    parameter int DEPTH = RC_DEPTH,
    parameter int AW    = RC_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wr_addr < AW'(DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Address space is larger than DEPTH; unpopulated addresses read 0.
    always_comb begin
        rd_data = '0;
        if (rd_addr < AW'(DEPTH)) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/result_collector.sv
// result_collector
//   Captures the accumulator result stream of the compute stage into a
//   small result memory, saturating each result to 8 bits and storing it
//   at sequential addresses. Once DEPTH entries are stored the buffer is
//   handed to the display stage, which reads it through addr_result_i
//   until it reports done.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start_i; memory holds the previous collection
//   S_COLLECT | storing results at wr_count, busy_o high
//   S_DISPLAY | buffer full and frozen, run_display_o high until done
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   start_i         begin / restart a collection (ignored in S_DISPLAY)
//   wr_valid_i      wr_data_i carries a valid result
//   wr_data_i       unsigned accumulator result
//   addr_result_i   display-stage read address
//   done_display_i  display stage finished with the buffer
//   result_o        entry at addr_result_i (combinational)
//   run_display_o   buffer full, display may run
//   busy_o          collection in progress
//   wr_count_o      entries written in the current collection
//   sat_o           sticky: a result was clamped this collection
//   overflow_o      sticky: a result arrived while not collecting
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DEPTH = RC_DEPTH,
    parameter int IN_W  = RC_IN_W,
    parameter int AW    = RC_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            wr_valid_i,
    input  logic [IN_W-1:0] wr_data_i,
    input  logic [AW-1:0]   addr_result_i,
    input  logic            done_display_i,
    output logic [7:0]      result_o,
    output logic            run_display_o,
    output logic            busy_o,
    output logic [AW-1:0]   wr_count_o,
    output logic            sat_o,
    output logic            overflow_o
);

    rc_state_t     state;
    rc_state_t     state_nxt;
    logic [AW-1:0] wr_count;
    logic          sat_flag;
    logic          ovf_flag;

    logic          restart;
    logic          mem_we;
    logic          last_write;
    logic          clamp;
    logic [7:0]    sat_data;

    // A start pulse wins over a concurrent write; in S_DISPLAY it is ignored.
    assign restart    = start_i && (state != S_DISPLAY);
    assign mem_we     = (state == S_COLLECT) && wr_valid_i && !start_i;
    assign last_write = (wr_count == AW'(DEPTH - 1));

    assign clamp    = |wr_data_i[IN_W-1:8];
    assign sat_data = clamp ? 8'hFF : wr_data_i[7:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (mem_we && last_write) begin
                    state_nxt = S_DISPLAY;
                end
            end
            S_DISPLAY: begin
                if (done_display_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; state is registered so these are glitch-free.
    always_comb begin
        run_display_o = 1'b0;
        busy_o        = 1'b0;
        case (state)
            S_COLLECT: busy_o        = 1'b1;
            S_DISPLAY: run_display_o = 1'b1;
            default: begin
                run_display_o = 1'b0;
                busy_o        = 1'b0;
            end
        endcase
    end

    // Write counter and sticky status flags. After the last write the
    // counter rests at DEPTH so the display stage can see a full buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else if (restart) begin
            wr_count <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (mem_we) begin
                wr_count <= wr_count + AW'(1);
                if (clamp) begin
                    sat_flag <= 1'b1;
                end
            end
            if (wr_valid_i && (state != S_COLLECT)) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    assign wr_count_o = wr_count;
    assign sat_o      = sat_flag;
    assign overflow_o = ovf_flag;

    result_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .wr_addr (wr_count),
        .wr_data (sat_data),
        .rd_addr (addr_result_i),
        .rd_data (result_o)
    );

endmodule

// File: tb/tb_result_collector.sv
`timescale 1ns/1ps
module tb_result_collector;

    localparam int DEPTH = 12;
    localparam int IN_W  = 16;
    localparam int AW    = 4;

    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_SHOW    = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start_i = 1'b0;
    logic            wr_valid_i = 1'b0;
    logic [IN_W-1:0] wr_data_i = '0;
    logic [AW-1:0]   addr_result_i = '0;
    logic            done_display_i = 1'b0;
    logic [7:0]      result_o;
    logic            run_display_o;
    logic            busy_o;
    logic [AW-1:0]   wr_count_o;
    logic            sat_o;
    logic            overflow_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: buffer contents, fill level and phase of the run.
    int m_mem [16] = '{default: 0};
    int m_count = 0;
    int m_phase = PH_IDLE;
    int m_sat = 0;
    int m_ovf = 0;

    result_collector dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .wr_valid_i     (wr_valid_i),
        .wr_data_i      (wr_data_i),
        .addr_result_i  (addr_result_i),
        .done_display_i (done_display_i),
        .result_o       (result_o),
        .run_display_o  (run_display_o),
        .busy_o         (busy_o),
        .wr_count_o     (wr_count_o),
        .sat_o          (sat_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_count = 0;
        m_phase = PH_IDLE;
        m_sat   = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        int d;
        d = int'(wr_data_i);
        if (m_phase == PH_IDLE) begin
            if (start_i) begin
                m_phase = PH_COLLECT;
                m_count = 0; m_sat = 0; m_ovf = 0;
            end else if (wr_valid_i) begin
                m_ovf = 1;
            end
        end else if (m_phase == PH_COLLECT) begin
            if (start_i) begin
                m_count = 0; m_sat = 0; m_ovf = 0;
            end else if (wr_valid_i) begin
                m_mem[m_count] = (d > 255) ? 255 : d;
                if (d > 255) m_sat = 1;
                m_count++;
                if (m_count == DEPTH) m_phase = PH_SHOW;
            end
        end else begin
            if (wr_valid_i) m_ovf = 1;
            if (done_display_i) m_phase = PH_IDLE;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("run_display", int'(run_display_o), int'(m_phase == PH_SHOW));
        check("busy",        int'(busy_o),        int'(m_phase == PH_COLLECT));
        check("wr_count",    int'(wr_count_o),    m_count);
        check("sat",         int'(sat_o),         m_sat);
        check("overflow",    int'(overflow_o),    m_ovf);
        check("result",      int'(result_o),      m_mem[addr_result_i]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_done();
        done_display_i = 1'b1;
        tick();
        done_display_i = 1'b0;
    endtask

    task automatic write(input int d);
        wr_valid_i    = 1'b1;
        wr_data_i     = IN_W'(d);
        addr_result_i = AW'((m_count < DEPTH) ? m_count : 0);
        tick();
        wr_valid_i    = 1'b0;
    endtask

    task automatic peek(input string name, input int a, input int exp);
        addr_result_i = AW'(a);
        #0.2;
        check(name, int'(result_o), exp);
    endtask

    initial begin
        // Reset state, before any clock edge.
        #2;
        check("rst_run",   int'(run_display_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_count", int'(wr_count_o), 0);
        check("rst_sat",   int'(sat_o), 0);
        check("rst_ovf",   int'(overflow_o), 0);
        check("rst_res",   int'(result_o), 0);
        #11;
        reset = 1'b1;
        tick();

        // Result arriving while idle: flagged, not stored.
        write(5);
        check("idle_ovf",   int'(overflow_o), 1);
        check("idle_count", int'(wr_count_o), 0);
        peek("idle_mem0", 0, 0);

        // Full collection of 0..11.
        pulse_start();
        check("start_busy", int'(busy_o), 1);
        check("start_ovf",  int'(overflow_o), 0);
        for (int i = 0; i < DEPTH; i++) write(i);
        check("full_run",   int'(run_display_o), 1);
        check("full_busy",  int'(busy_o), 0);
        check("full_count", int'(wr_count_o), 12);
        check("full_sat",   int'(sat_o), 0);
        for (int i = 0; i < DEPTH; i++) peek("full_mem", i, i);
        peek("oob12", 12, 0);
        peek("oob15", 15, 0);
        pulse_done();
        check("done_run",  int'(run_display_o), 0);
        check("done_busy", int'(busy_o), 0);
        peek("done_mem3", 3, 3);

        // Saturation.
        pulse_start();
        write(16'h0100);
        peek("sat_0100", 0, 255);
        check("sat_set", int'(sat_o), 1);
        write(16'hFFFF);
        peek("sat_ffff", 1, 255);
        write(16'h00FF);
        peek("sat_00ff", 2, 255);
        check("sat_hold", int'(sat_o), 1);
        pulse_start();
        check("rs_count", int'(wr_count_o), 0);
        check("rs_sat",   int'(sat_o), 0);
        write(16'h00FF);
        check("ff_nosat", int'(sat_o), 0);
        peek("ff_mem0", 0, 255);

        // Restart with a concurrent write after 5 entries.
        for (int i = 1; i < 5; i++) write(20 + i);
        check("five_count", int'(wr_count_o), 5);
        start_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 16'd7; addr_result_i = '0;
        tick();
        start_i = 1'b0; wr_valid_i = 1'b0;
        check("rsw_count", int'(wr_count_o), 0);
        check("rsw_busy",  int'(busy_o), 1);
        peek("rsw_mem0", 0, 255);
        for (int i = 0; i < DEPTH - 1; i++) write(100 + i);
        check("eleven_run",   int'(run_display_o), 0);
        check("eleven_count", int'(wr_count_o), 11);
        write(111);
        check("twelve_run", int'(run_display_o), 1);
        peek("rsw_new0", 0, 100);
        peek("rsw_new11", 11, 111);

        // Display phase: late data dropped, start ignored.
        wr_valid_i = 1'b1; wr_data_i = 16'h0042;
        tick();
        wr_valid_i = 1'b0;
        check("disp_ovf",   int'(overflow_o), 1);
        check("disp_count", int'(wr_count_o), 12);
        peek("disp_mem4", 4, 104);
        pulse_start();
        check("disp_st_busy", int'(busy_o), 0);
        check("disp_st_run",  int'(run_display_o), 1);
        pulse_done();
        check("disp_done_run",  int'(run_display_o), 0);
        check("disp_done_busy", int'(busy_o), 0);
        check("disp_done_ovf",  int'(overflow_o), 1);
        peek("disp_done_mem7", 7, 107);

        // Back-to-back collection.
        pulse_start();
        check("b2b_ovf",  int'(overflow_o), 0);
        check("b2b_sat",  int'(sat_o), 0);
        check("b2b_busy", int'(busy_o), 1);
        for (int i = 0; i < DEPTH; i++) write(50 + 20 * i);
        check("b2b_run", int'(run_display_o), 1);
        check("b2b_satset", int'(sat_o), 1);
        peek("b2b_mem0", 0, 50);
        peek("b2b_mem10", 10, 250);
        peek("b2b_mem11", 11, 255);
        pulse_done();

        // Asynchronous reset in the middle of a collection.
        pulse_start();
        for (int i = 0; i < 7; i++) write(i + 1);
        check("pre_rst_count", int'(wr_count_o), 7);
        #2;
        reset = 1'b0;
        #0.5;
        check("arst_run",   int'(run_display_o), 0);
        check("arst_busy",  int'(busy_o), 0);
        check("arst_count", int'(wr_count_o), 0);
        check("arst_sat",   int'(sat_o), 0);
        check("arst_ovf",   int'(overflow_o), 0);
        for (int a = 0; a < 16; a++) peek("arst_mem", a, 0);
        #1;
        reset = 1'b1;
        tick();
        check("post_rst_busy", int'(busy_o), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Upstream neighbour of the display stage.
- Captures the stream of accumulator results produced by the compute stage (PE, 2x2 and 3x3 systolic-array runs) into a small result memory.
- Saturates each result to 8 bits and stores it at sequential addresses.
- When the memory is full, raises run_display and serves the display stage's read address combinationally until the display stage reports done.

Parameters:
- DEPTH, 12, number of result entries (addresses 0..DEPTH-1).
- IN_W, 16, width of incoming unsigned accumulator result.
- AW, 4, address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle pulse: begin (or restart) a collection.
- wr_valid_i  input  1  wr_data_i holds a valid result this cycle.
- wr_data_i  input  IN_W  unsigned accumulator result.
- addr_result_i  input  AW  read address driven by the display stage.
- done_display_i  input  1  display stage has finished consuming the buffer.
- result_o  output  8  stored entry at addr_result_i.
- run_display_o  output  1  buffer full; display may run (state == S_DISPLAY).
- busy_o  output  1  collection in progress (state == S_COLLECT).
- wr_count_o  output  AW  entries written so far in the current collection.
- sat_o  output  1  sticky: at least one result was clamped this collection.
- overflow_o  output  1  sticky: wr_valid_i arrived while not collecting.

Behaviour:
- Reset (asynchronous, reset == 0):
  - state = S_IDLE.
  - All memory entries = 0.
  - wr_count_o = 0.
  - run_display_o, busy_o, sat_o and overflow_o = 0.
  - result_o reflects memory, so it reads 0.
- FSM states: S_IDLE, S_COLLECT, S_DISPLAY. All outputs are registered except result_o.
- S_IDLE:
  - start_i -> S_COLLECT next cycle; wr_count cleared to 0; sat_o and overflow_o cleared.
  - wr_valid_i without start_i -> overflow_o set, no write.
- S_COLLECT:
  - Each cycle with wr_valid_i: mem[wr_count] <= sat(wr_data_i); wr_count <= wr_count+1.
  - sat(x) = 255 if x > 255, else x[7:0]. sat_o is set when clamping occurs.
  - On the write of entry DEPTH-1: go to S_DISPLAY; run_display_o = 1 the next cycle; wr_count_o holds DEPTH.
  - start_i (with or without wr_valid_i): restart. wr_count = 0, sticky flags cleared, the concurrent write is discarded, state stays S_COLLECT. Old memory contents are not erased.
- S_DISPLAY:
  - Memory is frozen.
  - wr_valid_i -> overflow_o set, data dropped.
  - start_i is ignored.
  - done_display_i -> S_IDLE next cycle; run_display_o falls with that edge; memory keeps its contents.
- done_display_i outside S_DISPLAY is ignored.
- Read path:
  - result_o = mem[addr_result_i], combinational, zero latency, valid in every state.
  - addr_result_i >= DEPTH returns 8'h00.
- Same-cycle write and read of one address during S_COLLECT returns the old value (write takes effect at the clock edge).
- Write latency: data is visible on result_o the cycle after its wr_valid_i edge.
- Reset mid-collection or mid-display returns everything to the reset state immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - the state encoding (S_IDLE=2'd0, S_COLLECT=2'd1, S_DISPLAY=2'd2), shared with the top controller and the display stage;
  - the DEPTH/AW constants;
  - segment base addresses: PE results 0..3, SA 2x2 results 4..7, SA 3x3 results 8..11.
- One sub-module is natural: result_mem. It is a DEPTH x 8 register file with synchronous write, asynchronous read, async active-low clear, and an out-of-range read returning 0.
- The FSM, counter and saturation logic stay in result_collector.

Test Plan:
- Reset, then start_i, then 12 writes with values 0..11 -> run_display_o = 1 one cycle after the 12th write; addresses 0..11 read back 0..11; address 12 and address 15 read 0; sat_o = 0.
- Write 16'h0100 and 16'hFFFF -> stored value 255 for both, sat_o = 1; write 16'h00FF -> stored 255, sat_o unchanged by that write.
- After 5 writes, pulse start_i together with wr_valid_i(data 7) -> wr_count_o = 0, entry 0 not overwritten by 7; 12 further writes are needed before run_display_o is raised.
- In S_DISPLAY, wr_valid_i with 16'h0042 -> overflow_o = 1, memory unchanged; start_i ignored; done_display_i -> run_display_o = 0 and busy_o = 0 on the next cycle; contents still readable.
- Assert reset asynchronously between clock edges during S_COLLECT after 7 writes -> all outputs and every entry read 0 before the next clock edge.
- Back-to-back collections: done_display_i followed by start_i on the next cycle -> new collection overwrites entries 0..11; sticky flags cleared at start.
